// File: rtl/pool_sched.sv
// Layer controller for the 4-lane pooling datapath: latches geometry and lane mask,
// gates pool_en from the pixel stream, counts pixels and pooled results, reports done/err.
module pool_sched #(
  parameter int CH            = 4,
  parameter int WB            = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WB-1:0] cfg_o_width,
  input  logic [WB-1:0] cfg_o_height,
  input  logic [CH-1:0] cfg_ch_mask,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CH-1:0] pool_en,
  output logic [WB-1:0] pool_o_width,
  input  logic [CH-1:0] pool_result_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int RW = 2 * WB;
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [WB-1:0] ow_q, ow_d, oh_q, oh_d, pow_q, pow_d;
  logic [CH-1:0] mask_q, mask_d;
  logic [RW-1:0] total_q, total_d, res_q, res_d;
  logic [WB:0]   col_q, col_d, row_q, row_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;

  logic          in_run, counting, cfg_ok;
  logic          strobe_good, strobe_bad, res_full, res_inc;
  logic [WB:0]   col_last, row_last;

  assign in_run      = (state_q == S_RUN);
  assign counting    = in_run || (state_q == S_DRAIN);
  assign cfg_ok      = (cfg_o_width != '0) && (cfg_o_height != '0) && (cfg_ch_mask != '0);
  assign col_last    = {ow_q, 1'b0} - (WB+1)'(1);
  assign row_last    = {oh_q, 1'b0} - (WB+1)'(1);
  // A result counts only when exactly the active lanes strobe together.
  assign strobe_good = counting && (pool_result_valid == mask_q);
  assign strobe_bad  = counting && (pool_result_valid != '0) && (pool_result_valid != mask_q);
  assign res_full    = (res_q == total_q);
  assign res_inc     = strobe_good && !res_full;

  // Lane enables are decoded from state so a reset removes them without waiting for a clock.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      assign pool_en[gi] = in_run & in_valid & mask_q[gi];
    end
  endgenerate

  assign in_ready     = in_run;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign pool_o_width = pow_q;
  assign err          = err_q;

  always_comb begin
    state_d = state_q;
    ow_d    = ow_q;
    oh_d    = oh_q;
    mask_d  = mask_q;
    pow_d   = pow_q;
    total_d = total_q;
    res_d   = res_q;
    col_d   = col_q;
    row_d   = row_q;
    to_d    = to_q;
    err_d   = err_q;

    if (res_inc) begin
      res_d = res_q + RW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            ow_d    = cfg_o_width;
            oh_d    = cfg_o_height;
            mask_d  = cfg_ch_mask;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        pow_d   = ow_q;
        total_d = RW'(ow_q) * RW'(oh_q);
        col_d   = '0;
        row_d   = '0;
        res_d   = '0;
        to_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        to_d = '0;
        if (in_valid) begin
          if (col_q == col_last) begin
            col_d = '0;
            if (row_q == row_last) begin
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + (WB+1)'(1);
            end
          end else begin
            col_d = col_q + (WB+1)'(1);
          end
        end
      end
      S_DRAIN: begin
        // to_q holds the number of silent drain cycles since entry or the last result.
        if (res_d == total_q) begin
          state_d = S_DONE;
        end else if (res_inc) begin
          to_d = TW'(1);
        end else begin
          to_d = to_q + TW'(1);
          if (to_d == TW'(DRAIN_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (strobe_bad || (strobe_good && res_full)) begin
      err_d = 1'b1;
    end
    if (start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ow_q    <= '0;
      oh_q    <= '0;
      mask_q  <= '0;
      pow_q   <= '0;
      total_q <= '0;
      res_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ow_q    <= ow_d;
      oh_q    <= oh_d;
      mask_q  <= mask_d;
      pow_q   <= pow_d;
      total_q <= total_d;
      res_q   <= res_d;
      col_q   <= col_d;
      row_q   <= row_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pool_sched.sv
// Randomised layer-level bench for pool_sched: each layer's expected pool_en, in_ready,
// done cycle and err are derived from pixel/result counts and the drain timeout rule.
module tb_pool_sched;

  localparam int CH = 4;
  localparam int WB = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [WB-1:0] cfg_w = '0;
  logic [WB-1:0] cfg_h = '0;
  logic [CH-1:0] cfg_m = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CH-1:0] pool_en;
  logic [WB-1:0] pool_o_width;
  logic [CH-1:0] prv = '0;
  logic          busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pool_sched #(.CH(CH), .WB(WB), .DRAIN_TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_o_width      (cfg_w),
    .cfg_o_height     (cfg_h),
    .cfg_ch_mask      (cfg_m),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .pool_en          (pool_en),
    .pool_o_width     (pool_o_width),
    .pool_result_valid(prv),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A strobe pattern that is neither idle nor the full mask.
  function automatic logic [3:0] partial_of(input logic [3:0] m);
    logic [3:0] r;
    if ($countones(m) > 1) r = m & (m - 4'd1);
    else if (m == 4'h8)    r = 4'h9;
    else                   r = m | (m << 1);
    return r;
  endfunction

  // stall: 0 none, 1 every other cycle, 2 random.
  task automatic run_layer(input string name, input int ow, input int oh, input logic [3:0] mask,
                           input int stall, input int n_good, input bit inj_partial, input bit inj_start);
    int need, nres, pix_acc, good_sent, t, last_pix, last_res, exp_done, gap, anchor;
    bit pix_phase, v, err_exp, finished;
    logic [3:0] sv;
    need      = 4 * ow * oh;
    nres      = ow * oh;
    pix_acc   = 0;
    good_sent = 0;
    last_pix  = -1;
    last_res  = -1;
    exp_done  = -1;
    finished  = 1'b0;
    gap       = int'($urandom_range(0, 8));
    err_exp   = inj_partial || inj_start || (n_good < nres);

    cfg_w = 4'(ow); cfg_h = 4'(oh); cfg_m = mask;
    start = 1'b1; in_valid = 1'b0; prv = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 0; t < 4000; t++) begin
      pix_phase = (t >= 1) && (pix_acc < need);
      case (stall)
        0:       v = 1'b1;
        1:       v = (t % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (!pix_phase) v = ($urandom_range(0, 1) == 1);
      in_valid = v;
      sv = '0;
      if (t >= 1 && exp_done < 0) begin
        if (pix_phase) begin
          if (inj_partial && t == 1) sv = partial_of(mask);
          else if (good_sent < n_good && $urandom_range(0, 5) == 0) sv = mask;
        end else if (good_sent < n_good) begin
          if (gap == 0) begin
            sv  = mask;
            gap = int'($urandom_range(0, 12));
          end else begin
            gap--;
          end
        end
      end
      prv = sv;
      if (inj_start && t == 3) begin
        start = 1'b1;
        cfg_w = 4'(ow + 1);
      end
      #1;
      if (exp_done >= 0 && t == exp_done + 1) begin
        check("busy_after", 32'(busy), 32'(0));
        check("done_after", 32'(done), 32'(0));
        check("err_sticky", 32'(err), 32'(err_exp));
        finished = 1'b1;
        break;
      end
      check("in_ready", 32'(in_ready), 32'(pix_phase));
      check("pool_en", 32'(pool_en), 32'((pix_phase && v) ? mask : 4'h0));
      check("busy", 32'(busy), 32'(1));
      check("done", 32'(done), 32'(t == exp_done));
      if (t == 0) check("err_cleared", 32'(err), 32'(0));
      if (t >= 1) check("pool_o_width", 32'(pool_o_width), 32'(ow));
      if (t == exp_done) check("err_at_done", 32'(err), 32'(err_exp));

      if (pix_phase && v) begin
        pix_acc++;
        if (pix_acc == need) last_pix = t;
      end
      if (t >= 1 && sv == mask) begin
        good_sent++;
        last_res = t;
      end
      if (exp_done < 0 && pix_acc == need && good_sent >= n_good) begin
        anchor   = (last_res > last_pix + 1) ? last_res : last_pix + 1;
        exp_done = anchor + ((good_sent == nres) ? 1 : TO);
      end
      @(posedge clk); #1;
      start = 1'b0;
      prv   = '0;
    end
    if (!finished) check("layer_bound", 32'(0), 32'(1));
    in_valid = 1'b0;
    $display("layer %-10s ow=%0d oh=%0d mask=%h pixels=%0d good=%0d done_t=%0d err=%0b",
             name, ow, oh, mask, pix_acc, good_sent, exp_done, err_exp);
  endtask

  task automatic bad_start(input string name, input logic [3:0] w, input logic [3:0] h, input logic [3:0] m);
    cfg_w = w; cfg_h = h; cfg_m = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check({name, "_err"}, 32'(err), 32'(1));
    check({name, "_busy"}, 32'(busy), 32'(0));
    @(posedge clk); #2;
    check({name, "_idle"}, 32'(busy), 32'(0));
    $display("bad start %s w=%0d h=%0d m=%h", name, w, h, m);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_pool_en", 32'(pool_en), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_ow", 32'(pool_o_width), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN with a pixel presented.
    cfg_w = 4'd3; cfg_h = 4'd3; cfg_m = 4'hF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    #1;
    check("t1_pool_en_run", 32'(pool_en), 32'(4'hF));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_err_busy_start", 32'(err), 32'(1));
    rst = 1'b1;
    #1;
    check("t1_pool_en_rst", 32'(pool_en), 32'(0));
    check("t1_busy_rst", 32'(busy), 32'(0));
    check("t1_err_rst", 32'(err), 32'(0));
    check("t1_ready_rst", 32'(in_ready), 32'(0));
    check("t1_ow_rst", 32'(pool_o_width), 32'(0));
    $display("reset mid-layer applied");
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;

    run_layer("c3", 5, 5, 4'hF, 0, 25, 1'b0, 1'b0);
    run_layer("stall", 2, 2, 4'h3, 1, 4, 1'b0, 1'b0);
    run_layer("partial", 3, 2, 4'hF, 2, 5, 1'b1, 1'b0);
    bad_start("ow0", 4'd0, 4'd3, 4'hF);
    bad_start("oh0", 4'd3, 4'd0, 4'hF);
    bad_start("mask0", 4'd3, 4'd3, 4'h0);
    run_layer("busy_start", 3, 3, 4'h5, 2, 9, 1'b0, 1'b1);
    run_layer("clears", 2, 3, 4'h9, 0, 6, 1'b0, 1'b0);
    run_layer("timeout", 1, 1, 4'hF, 0, 0, 1'b0, 1'b0);
    run_layer("single", 1, 1, 4'h2, 2, 1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_layer("random", int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), m,
                int'($urandom_range(0, 2)), 0, 1'b0, 1'b0);
    end
    run_layer("c1", 14, 14, 4'hF, 0, 196, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
